// File: rtl/led_pwm_dimmer.sv
// Per-channel LED PWM dimmer with glitch-free duty update and linear fade.
// Duty changes land only on the period boundary so no pulse is ever cut short.
module led_pwm_dimmer #(
  parameter int NUM_LEDS     = 4,
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 64,
  parameter int DEFAULT_DUTY = 128
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_LEDS-1:0]      leds_i,
  input  logic                     wr_en,
  input  logic                     wr_bcast,
  input  logic [(NUM_LEDS>1 ? $clog2(NUM_LEDS) : 1)-1:0] wr_sel,
  input  logic [PWM_BITS-1:0]      wr_duty,
  input  logic                     fade_en,
  output logic [NUM_LEDS-1:0]      leds_o,
  output logic                     busy
);

  localparam int MAX   = 2**PWM_BITS - 1;
  localparam int PS_W  = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int SEL_W = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;

  typedef logic [PWM_BITS-1:0] duty_t;

  logic [PS_W-1:0]                  presc;
  duty_t                            pwm_cnt;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] cur_q;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] cur_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] tgt_q;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] tgt_d;
  logic [NUM_LEDS-1:0]              on;
  logic [NUM_LEDS-1:0]              diff;
  logic                             tick;
  logic                             pstart;

  assign tick   = (presc == PS_W'(PRESCALE - 1));
  assign pstart = tick && (pwm_cnt == duty_t'(MAX - 1));

  // Out-of-range wr_sel matches no channel, so the write drops out.
  always_comb begin
    cur_d = cur_q;
    tgt_d = tgt_q;
    on    = '0;
    diff  = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (wr_en && (wr_bcast || wr_sel == SEL_W'(i)))
        tgt_d[i] = wr_duty;
      if (pstart) begin
        if (!fade_en)
          cur_d[i] = tgt_q[i];
        else if (cur_q[i] < tgt_q[i])
          cur_d[i] = cur_q[i] + 1'b1;
        else if (cur_q[i] > tgt_q[i])
          cur_d[i] = cur_q[i] - 1'b1;
      end
      on[i]   = (pwm_cnt < cur_q[i]);
      diff[i] = (cur_d[i] != tgt_d[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc   <= '0;
      pwm_cnt <= '0;
      cur_q   <= {NUM_LEDS{duty_t'(DEFAULT_DUTY)}};
      tgt_q   <= {NUM_LEDS{duty_t'(DEFAULT_DUTY)}};
      leds_o  <= '0;
      busy    <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        pwm_cnt <= pstart ? '0 : pwm_cnt + 1'b1;
      cur_q  <= cur_d;
      tgt_q  <= tgt_d;
      leds_o <= leds_i & on;
      busy   <= |diff;
    end
  end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed bench: default-sized dimmer for reset/period,
// 4-bit tick-per-cycle dimmer for extremes, gating, writes, fade, reset.
module tb_led_pwm_dimmer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [3:0] leds_i;
  logic       wr_en;
  logic       wr_bcast;
  logic [1:0] wr_sel;
  logic [3:0] wr_duty;
  logic       fade_en;
  logic [3:0] leds_o;
  logic       busy;

  logic       d_zero = 1'b0;
  logic [1:0] d_sel  = 2'd0;
  logic [7:0] d_duty = 8'd0;
  logic [3:0] d_leds_o;
  logic       d_busy;

  led_pwm_dimmer #(
    .NUM_LEDS(4), .PWM_BITS(4), .PRESCALE(1), .DEFAULT_DUTY(8)
  ) u_dut (
    .clk(clk), .resetn(resetn), .leds_i(leds_i),
    .wr_en(wr_en), .wr_bcast(wr_bcast), .wr_sel(wr_sel),
    .wr_duty(wr_duty), .fade_en(fade_en),
    .leds_o(leds_o), .busy(busy)
  );

  led_pwm_dimmer u_def (
    .clk(clk), .resetn(resetn), .leds_i(leds_i),
    .wr_en(d_zero), .wr_bcast(d_zero), .wr_sel(d_sel),
    .wr_duty(d_duty), .fade_en(d_zero),
    .leds_o(d_leds_o), .busy(d_busy)
  );

  int vectors = 0;
  int errs    = 0;
  int ph      = 0;
  int cnt [4];
  int dcnt[4];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ph mirrors the 4-bit DUT's pwm_cnt (period 15, tick every clk)
  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph == 14) ? 0 : ph + 1;
  endtask

  task automatic next_pstart();
    do step(); while (ph != 0);
  endtask

  task automatic wr(input logic b, input logic [1:0] s,
                    input logic [3:0] d);
    wr_en    = 1'b1;
    wr_bcast = b;
    wr_sel   = s;
    wr_duty  = d;
    step();
    wr_en    = 1'b0;
    wr_bcast = 1'b0;
  endtask

  task automatic measure(input int n);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    repeat (n) begin
      step();
      for (int i = 0; i < 4; i++)
        if (leds_o[i]) cnt[i]++;
    end
  endtask

  initial begin
    resetn   = 1'b0;
    leds_i   = 4'hF;
    wr_en    = 1'b0;
    wr_bcast = 1'b0;
    wr_sel   = 2'd0;
    wr_duty  = 4'd0;
    fade_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", leds_o, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_def_leds", d_leds_o, 4'h0);
    chk("rst_def_busy", d_busy, 1'b0);

    // default dimmer: 128 of 255 ticks, 64 clk per tick
    resetn = 1'b1;
    ph = 0;
    for (int i = 0; i < 4; i++) dcnt[i] = 0;
    for (int k = 1; k <= 255 * 64; k++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (d_leds_o[i]) dcnt[i]++;
      if (k == 1)    chk("def_first_on", d_leds_o, 4'hF);
      if (k == 8192) chk("def_last_on", d_leds_o, 4'hF);
      if (k == 8193) chk("def_first_off", d_leds_o, 4'h0);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("def_high_ch%0d", i), dcnt[i], 128 * 64);
    chk("def_busy", d_busy, 1'b0);

    // extremes
    wr(1'b0, 2'd0, 4'd0);
    wr(1'b0, 2'd1, 4'd15);
    chk("ext_busy_set", busy, 1'b1);
    next_pstart();
    chk("ext_busy_clr", busy, 1'b0);
    measure(45);
    chk("ext_ch0_never_on", cnt[0], 0);
    chk("ext_ch1_never_off", cnt[1], 45);

    // gating
    leds_i = 4'b0101;
    wr(1'b1, 2'd0, 4'd8);
    next_pstart();
    measure(15);
    chk("gate_ch0", cnt[0], 8);
    chk("gate_ch1", cnt[1], 0);
    chk("gate_ch2", cnt[2], 8);
    chk("gate_ch3", cnt[3], 0);

    // write collisions
    leds_i = 4'hF;
    wr(1'b1, 2'd0, 4'd10);
    wr(1'b0, 2'd3, 4'd3);
    next_pstart();
    measure(15);
    chk("coll_ch0", cnt[0], 10);
    chk("coll_ch2", cnt[2], 10);
    chk("coll_ch3", cnt[3], 3);
    while (ph != 14) step();
    wr(1'b0, 2'd0, 4'd5);
    chk("pst_wr_busy", busy, 1'b1);
    measure(15);
    chk("pst_wr_old", cnt[0], 10);
    chk("pst_wr_busy_clr", busy, 1'b0);
    measure(15);
    chk("pst_wr_new", cnt[0], 5);

    // fade 2 -> 6 on ch2
    wr(1'b0, 2'd2, 4'd2);
    next_pstart();
    chk("fade_pre_busy", busy, 1'b0);
    fade_en = 1'b1;
    wr(1'b0, 2'd2, 4'd6);
    chk("fade_wr_busy", busy, 1'b1);
    next_pstart();
    chk("fade_busy_3", busy, 1'b1);
    measure(15);
    chk("fade_cur3", cnt[2], 3);
    chk("fade_busy_4", busy, 1'b1);
    measure(15);
    chk("fade_cur4", cnt[2], 4);
    chk("fade_busy_5", busy, 1'b1);
    measure(15);
    chk("fade_cur5", cnt[2], 5);
    chk("fade_busy_6", busy, 1'b0);
    measure(15);
    chk("fade_cur6", cnt[2], 6);
    chk("fade_done_busy", busy, 1'b0);

    // reset mid-fade at current 4
    fade_en = 1'b0;
    wr(1'b0, 2'd2, 4'd2);
    next_pstart();
    fade_en = 1'b1;
    wr(1'b0, 2'd2, 4'd6);
    next_pstart();
    next_pstart();
    step();
    chk("mid_leds_on", leds_o, 4'hF);
    chk("mid_busy", busy, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_leds", leds_o, 4'h0);
    chk("mid_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    ph = 0;
    measure(15);
    chk("post_rst_ch0", cnt[0], 8);
    chk("post_rst_ch2", cnt[2], 8);
    chk("post_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
